muldiv_seq: RTL and testbench

Iterative multiply/divide sequencer beside the ALU in the multi-cycle ARM core. Executes UMULL/SMULL (64-bit product) and UDIV (quotient/remainder) over WIDTH+1 cycles, one bit per cycle. Uses a start/busy/done handshake. The main controller FSM holds in its execute state while Busy is high. On Done, the controller writes ResultLo to Rd and ResultHi to the high register through the RegWriteHi path.

---
 rtl/muldiv_pkg.sv | 17 +
 rtl/muldiv_dp.sv | 108 ++++++++++
 rtl/muldiv_seq.sv | 85 ++++++++
 tb/tb_muldiv_seq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and defaults for the iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [1:0] OP_UMULL = 2'b00;
  localparam logic [1:0] OP_SMULL = 2'b01;
  localparam logic [1:0] OP_UDIV  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_dp.sv
// Operand/accumulator datapath: shift-add multiply, restoring divide, final sign fix.
module muldiv_dp
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               finish,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic [WIDTH-1:0]   result_lo,
  output logic [WIDTH-1:0]   result_hi
);

  logic [1:0]         op_q;
  logic               neg_q;
  logic [2*WIDTH-1:0] a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc_q;

  logic [2*WIDTH-1:0] a_nx;
  logic [WIDTH-1:0]   b_nx;
  logic [2*WIDTH-1:0] acc_nx;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH+1:0]   diff;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;

  always_comb begin
    abs_a  = src_a[WIDTH-1] ? -src_a : src_a;
    abs_b  = src_b[WIDTH-1] ? -src_b : src_b;
    a_nx   = a_q;
    b_nx   = b_q;
    acc_nx = acc_q;
    // Divide: a_q holds the divisor, b_q shifts the dividend out and the quotient in.
    diff   = {1'b0, acc_q[WIDTH-1:0], b_q[WIDTH-1]} - {2'b00, a_q[WIDTH-1:0]};
    if (op_q == OP_UDIV) begin
      b_nx = {b_q[WIDTH-2:0], ~diff[WIDTH+1]};
      if (diff[WIDTH+1])
        acc_nx = {{WIDTH{1'b0}}, acc_q[WIDTH-2:0], b_q[WIDTH-1]};
      else
        acc_nx = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
    end else begin
      if (b_q[0])
        acc_nx = acc_q + a_q;
      a_nx = a_q << 1;
      b_nx = b_q >> 1;
    end
    prod = neg_q ? -acc_nx : acc_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= OP_UMULL;
      neg_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      result_lo <= '0;
      result_hi <= '0;
    end else if (load) begin
      op_q  <= op;
      acc_q <= '0;
      case (op)
        OP_SMULL: begin
          a_q   <= {{WIDTH{1'b0}}, abs_a};
          b_q   <= abs_b;
          neg_q <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
        end
        OP_UDIV: begin
          a_q   <= {{WIDTH{1'b0}}, src_b};
          b_q   <= src_a;
          neg_q <= 1'b0;
        end
        default: begin
          a_q   <= {{WIDTH{1'b0}}, src_a};
          b_q   <= src_b;
          neg_q <= 1'b0;
        end
      endcase
    end else if (step) begin
      a_q   <= a_nx;
      b_q   <= b_nx;
      acc_q <= acc_nx;
      if (finish) begin
        case (op_q)
          OP_UMULL, OP_SMULL: begin
            result_lo <= prod[WIDTH-1:0];
            result_hi <= prod[2*WIDTH-1:WIDTH];
          end
          OP_UDIV: begin
            result_lo <= b_nx;
            result_hi <= acc_nx[WIDTH-1:0];
          end
          default: begin
            result_lo <= '0;
            result_hi <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Start/busy/done sequencer: FSM and iteration counter around muldiv_dp.
// state | meaning
// IDLE  | waiting for Start, results held
// CALC  | one iteration per cycle, WIDTH cycles
// DONE  | one-cycle Done pulse, results valid
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             Kill,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ResultLo,
  output logic [WIDTH-1:0] ResultHi
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             step;
  logic             last;

  assign last = (cnt == CNT_W'(WIDTH - 1));
  assign load = (state == IDLE) && Start && !Kill;
  assign step = (state == CALC) && !Kill;

  always_ff @(posedge clk) begin
    if (reset || Kill) begin
      state <= IDLE;
      cnt   <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            state <= CALC;
            cnt   <= '0;
            Busy  <= 1'b1;
          end
        end
        CALC: begin
          if (last) begin
            state <= DONE;
            Done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

  muldiv_dp #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .finish    (step && last),
    .op        (Op),
    .src_a     (SrcA),
    .src_b     (SrcB),
    .result_lo (ResultLo),
    .result_hi (ResultHi)
  );

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq with hand-computed expectations.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        Kill;
  logic        Busy;
  logic        Done;
  logic [31:0] ResultLo;
  logic [31:0] ResultHi;

  int checks = 0;
  int errors = 0;
  int lat;
  int bc;
  int ndone;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .Start    (Start),
    .Op       (Op),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .Kill     (Kill),
    .Busy     (Busy),
    .Done     (Done),
    .ResultLo (ResultLo),
    .ResultHi (ResultHi)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Counts edges from the current sample point until Done is seen (bounded).
  task automatic wait_done(input bit vary, output int n, output int busy_cnt);
    n = 0;
    busy_cnt = Busy ? 1 : 0;
    while (!Done && n < 100) begin
      if (vary) begin
        SrcA = SrcA + 1;
        SrcB = SrcB + 3;
      end
      tick();
      n++;
      if (Busy) busy_cnt++;
    end
    if (!Done) chk("done_timeout", 64'(Done), 64'd1);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, output int n, output int busy_cnt);
    Start = 1'b1;
    Op    = op;
    SrcA  = a;
    SrcB  = b;
    tick();
    if (!hold) begin
      Start = 1'b0;
      SrcA  = 32'hDEAD_BEEF;
      SrcB  = 32'h1234_5678;
    end
    wait_done(hold, n, busy_cnt);
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (Done) cnt++;
    end
  endtask

  initial begin
    reset = 1'b1;
    Start = 1'b0;
    Op    = 2'b00;
    SrcA  = '0;
    SrcB  = '0;
    Kill  = 1'b0;
    tick();
    tick();
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_lo", 64'(ResultLo), 64'd0);
    chk("rst_hi", 64'(ResultHi), 64'd0);
    reset = 1'b0;
    tick();

    // UMULL max x max
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, bc);
    chk("umull_lat", 64'(lat), 64'd32);
    chk("umull_lo", 64'(ResultLo), 64'h0000_0001);
    chk("umull_hi", 64'(ResultHi), 64'hFFFF_FFFE);
    tick();
    chk("umull_busy_cycles", 64'(bc), 64'd33);
    chk("umull_done_pulse", 64'(Done), 64'd0);
    chk("umull_busy_off", 64'(Busy), 64'd0);

    // SMULL -3 * 7
    run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 1'b0, lat, bc);
    chk("smull1_lo", 64'(ResultLo), 64'hFFFF_FFEB);
    chk("smull1_hi", 64'(ResultHi), 64'hFFFF_FFFF);
    tick();

    // SMULL most-negative squared
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0, lat, bc);
    chk("smull2_lo", 64'(ResultLo), 64'h0);
    chk("smull2_hi", 64'(ResultHi), 64'h4000_0000);
    chk("smull2_lat", 64'(lat), 64'd32);
    tick();

    // UDIV 100 / 7
    run_op(2'b10, 32'd100, 32'd7, 1'b0, lat, bc);
    chk("udiv_q", 64'(ResultLo), 64'd14);
    chk("udiv_r", 64'(ResultHi), 64'd2);
    tick();

    // UDIV 5 / 0
    run_op(2'b10, 32'd5, 32'd0, 1'b0, lat, bc);
    chk("div0_q", 64'(ResultLo), 64'hFFFF_FFFF);
    chk("div0_r", 64'(ResultHi), 64'd5);
    chk("div0_lat", 64'(lat), 64'd32);
    tick();

    // Reserved op clears results after full latency
    run_op(2'b11, 32'd123, 32'd456, 1'b0, lat, bc);
    chk("rsvd_lat", 64'(lat), 64'd32);
    chk("rsvd_lo", 64'(ResultLo), 64'd0);
    chk("rsvd_hi", 64'(ResultHi), 64'd0);
    tick();

    // Start held high with changing operands
    run_op(2'b00, 32'd3, 32'd5, 1'b1, lat, bc);
    chk("hold_lat", 64'(lat), 64'd32);
    chk("hold_lo", 64'(ResultLo), 64'd15);
    chk("hold_hi", 64'(ResultHi), 64'd0);
    SrcA = 32'd10;
    SrcB = 32'd11;
    tick();
    chk("hold_done_pulse", 64'(Done), 64'd0);
    chk("hold_idle", 64'(Busy), 64'd0);
    tick();
    chk("hold_reaccept", 64'(Busy), 64'd1);
    Start = 1'b0;
    wait_done(1'b0, lat, bc);
    chk("hold2_lat", 64'(lat), 64'd32);
    chk("hold2_lo", 64'(ResultLo), 64'd110);
    tick();
    chk("hold2_done_pulse", 64'(Done), 64'd0);

    // Kill at CALC cycle 20 with Start high
    Start = 1'b1;
    Op    = 2'b00;
    SrcA  = 32'd7;
    SrcB  = 32'd9;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 19; i++) tick();
    chk("kill_pre_busy", 64'(Busy), 64'd1);
    Kill  = 1'b1;
    Start = 1'b1;
    tick();
    Kill  = 1'b0;
    Start = 1'b0;
    chk("kill_busy", 64'(Busy), 64'd0);
    chk("kill_done", 64'(Done), 64'd0);
    chk("kill_lo", 64'(ResultLo), 64'd110);
    chk("kill_hi", 64'(ResultHi), 64'd0);
    count_dones(40, ndone);
    chk("kill_no_done", 64'(ndone), 64'd0);
    chk("kill_no_accept", 64'(Busy), 64'd0);

    // Reset in CALC cycle 10
    Start = 1'b1;
    SrcA  = 32'd7;
    SrcB  = 32'd9;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid_busy", 64'(Busy), 64'd0);
    chk("rstmid_done", 64'(Done), 64'd0);
    chk("rstmid_lo", 64'(ResultLo), 64'd0);
    chk("rstmid_hi", 64'(ResultHi), 64'd0);
    count_dones(40, ndone);
    chk("rstmid_no_done", 64'(ndone), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
